// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - per-channel ReLU followed by streaming 2x2 stride-2 max pooling
// Partial maxima of even rows are parked in a half-width row buffer and merged on odd rows.
module relu_maxpool #(
  parameter int filter_total = 8,
  parameter int map_width    = 8,
  parameter int map_height   = 8,
  localparam int COL_W  = (map_width  > 1) ? $clog2(map_width)  : 1,
  localparam int ROW_W  = (map_height > 1) ? $clog2(map_height) : 1,
  localparam int PCW    = (map_width  > 2) ? $clog2(map_width / 2)  : 1,
  localparam int PRW    = (map_height > 2) ? $clog2(map_height / 2) : 1,
  localparam int HALF_W = map_width / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       conv_outs [filter_total],
  input  logic              conv_outs_valid,
  input  logic              clr,
  output logic [31:0]       pool_outs [filter_total],
  output logic              pool_valid,
  output logic [PCW-1:0]    pool_col,
  output logic [PRW-1:0]    pool_row,
  output logic              frame_done
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [31:0]      hold_q      [filter_total];
  logic [31:0]      hold_d      [filter_total];
  logic [31:0]      rowbuf_q    [HALF_W][filter_total];
  logic [31:0]      rowbuf_d    [HALF_W][filter_total];
  logic [31:0]      pool_outs_q [filter_total];
  logic [31:0]      pool_outs_d [filter_total];
  logic             pool_valid_q, pool_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PCW-1:0]   pool_col_q, pool_col_d;
  logic [PRW-1:0]   pool_row_q, pool_row_d;
  logic [31:0]      relu        [filter_total];
  logic [PCW-1:0]   half_col;
  logic             last_col, last_row;

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // After ReLU every value is non-negative, so unsigned compares order them correctly.
  always_comb begin
    for (int ch = 0; ch < filter_total; ch++) begin
      relu[ch] = conv_outs[ch][31] ? 32'd0 : conv_outs[ch];
    end
  end

  assign half_col = PCW'(col_q >> 1);
  assign last_col = (col_q == COL_W'(map_width - 1));
  assign last_row = (row_q == ROW_W'(map_height - 1));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    rowbuf_d     = rowbuf_q;
    pool_outs_d  = pool_outs_q;
    pool_col_d   = pool_col_q;
    pool_row_d   = pool_row_q;
    pool_valid_d = 1'b0;
    frame_done_d = 1'b0;
    if (clr) begin
      col_d = '0;
      row_d = '0;
      for (int ch = 0; ch < filter_total; ch++) hold_d[ch] = '0;
    end else if (conv_outs_valid) begin
      col_d = last_col ? '0 : col_q + COL_W'(1);
      if (last_col) row_d = last_row ? '0 : row_q + ROW_W'(1);
      case ({row_q[0], col_q[0]})
        2'b00: for (int ch = 0; ch < filter_total; ch++) hold_d[ch] = relu[ch];
        2'b01: for (int ch = 0; ch < filter_total; ch++)
                 rowbuf_d[half_col][ch] = max32(hold_q[ch], relu[ch]);
        2'b10: for (int ch = 0; ch < filter_total; ch++)
                 hold_d[ch] = max32(rowbuf_q[half_col][ch], relu[ch]);
        2'b11: begin
          for (int ch = 0; ch < filter_total; ch++)
            pool_outs_d[ch] = max32(hold_q[ch], relu[ch]);
          pool_col_d   = half_col;
          pool_row_d   = PRW'(row_q >> 1);
          pool_valid_d = 1'b1;
          frame_done_d = last_col && last_row;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      pool_col_q   <= '0;
      pool_row_q   <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      for (int ch = 0; ch < filter_total; ch++) begin
        hold_q[ch]      <= '0;
        pool_outs_q[ch] <= '0;
        for (int i = 0; i < HALF_W; i++) rowbuf_q[i][ch] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      rowbuf_q     <= rowbuf_d;
      pool_outs_q  <= pool_outs_d;
      pool_col_q   <= pool_col_d;
      pool_row_q   <= pool_row_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pool_outs  = pool_outs_q;
  assign pool_valid = pool_valid_q;
  assign pool_col   = pool_col_q;
  assign pool_row   = pool_row_q;
  assign frame_done = frame_done_q;

endmodule
